// File: rtl/pkt_rr_mux.sv
// Packet-granular round-robin arbiter and zero-latency datapath mux onto one shared output channel.
// Optional stall timeout on the granted port is enabled with the PKT_TIMEOUT_EN macro.
module pkt_rr_mux #(
  parameter int NUM_PORTS = 4,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PORTS-1:0]    in_srdy,
  output logic [NUM_PORTS-1:0]    in_drdy,
  input  logic [NUM_PORTS*DW-1:0] in_data,
  input  logic [NUM_PORTS-1:0]    in_eop,
  output logic                    out_srdy,
  input  logic                    out_drdy,
  output logic [DW-1:0]           out_data,
  output logic                    out_eop,
  output logic [NUM_PORTS-1:0]    grant
`ifdef PKT_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  if (NUM_PORTS < 2 || TIMEOUT < 1) begin : g_param_check
    $error("pkt_rr_mux: NUM_PORTS must be >= 2 and TIMEOUT >= 1");
  end

  logic [0:0]           r_state;
  logic [NUM_PORTS-1:0] r_grant;
  logic [IW-1:0]        r_last_owner;

  logic [IW-1:0]        w_gidx;
  logic [IW-1:0]        w_pick;
  logic [IW-1:0]        w_idx;
  logic                 w_any;
  logic                 w_hit;
  logic                 w_lock;
  logic                 w_xfer;

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_gidx = w_gidx | (r_grant[i] ? IW'(i) : '0);
    end
  end

  // Rotating scan: first requester after the last owner wins.
  always_comb begin
    w_pick = r_last_owner;
    w_any  = 1'b0;
    w_idx  = '0;
    w_hit  = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_idx  = IW'((int'(r_last_owner) + k) % NUM_PORTS);
      w_hit  = !w_any && in_srdy[w_idx];
      w_pick = w_hit ? w_idx : w_pick;
      w_any  = w_any | w_hit;
    end
  end

  assign w_lock   = (r_state == ST_LOCK);
  assign out_srdy = w_lock & in_srdy[w_gidx];
  assign out_data = in_data[w_gidx*DW +: DW];
  assign out_eop  = w_lock & in_eop[w_gidx];
  assign in_drdy  = r_grant & {NUM_PORTS{out_drdy}};
  assign w_xfer   = out_srdy & out_drdy;
  assign grant    = r_grant;

`ifdef PKT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;

  // Counts owner-idle cycles only; backpressure from downstream is not a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      if (!w_lock || w_xfer) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(TIMEOUT)) begin
        r_cnt         <= '0;
        r_timeout_err <= 1'b1;
      end else if (!in_srdy[w_gidx]) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_owner <= IW'(NUM_PORTS - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant      <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_pick;
            r_last_owner <= w_pick;
            r_state      <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_xfer && out_eop) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end
`ifdef PKT_TIMEOUT_EN
          else if (!w_xfer && r_cnt == CW'(TIMEOUT)) begin
            // Rotation pointer is left alone so the stalled port loses priority.
            r_grant <= '0;
            r_state <= ST_IDLE;
          end
`endif
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
